// File: rtl/fm_demod_pkg.sv
// Shared types and widths for the FM demodulator front end.
package fm_demod_pkg;

  localparam int unsigned BYTES_PER_SAMPLE = 4;
  localparam int unsigned SAMPLE_W         = 32;
  localparam int unsigned BYTE_W           = 8;
  localparam int unsigned HALF_W           = SAMPLE_W / 2;
  localparam int unsigned BCNT_W           = $clog2(BYTES_PER_SAMPLE);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FLUSH   = 2'd2
  } state_e;

  // One IQ sample as presented to the pipeline: real half in the upper bits.
  typedef struct packed {
    logic [HALF_W-1:0] re;
    logic [HALF_W-1:0] im;
  } iq_sample_t;

  // Width of a counter holding values 0..n-1 (never narrower than one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/iq_assembler.sv
// Packs UART bytes MSB first into 32-bit IQ words; drops stale partial words.
module iq_assembler
  import fm_demod_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en_i,
  input  logic                drop_i,
  input  logic                byte_valid_i,
  input  logic [BYTE_W-1:0]   byte_i,
  output logic [SAMPLE_W-1:0] word_c,
  output logic                complete_c,
  output logic                frame_err_o
);

  localparam int unsigned SH_W  = SAMPLE_W - BYTE_W;
  localparam int unsigned TMO_W = cnt_width(TIMEOUT);

  logic [SH_W-1:0]   shreg_q, shreg_d;
  logic [BCNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              frame_err_q, frame_err_d;

  // Byte shift, word completion, idle timeout and partial-word discard.
  always_comb begin
    shreg_d     = shreg_q;
    byte_cnt_d  = byte_cnt_q;
    tmo_d       = tmo_q;
    frame_err_d = 1'b0;
    complete_c  = 1'b0;
    word_c      = {shreg_q, byte_i};

    if (!en_i) begin
      byte_cnt_d = '0;
      tmo_d      = '0;
    end else begin
      if (byte_valid_i) begin
        shreg_d = {shreg_q[SH_W-BYTE_W-1:0], byte_i};
        tmo_d   = '0;
        if (byte_cnt_q == BCNT_W'(BYTES_PER_SAMPLE - 1)) begin
          complete_c = 1'b1;
          byte_cnt_d = '0;
        end else begin
          byte_cnt_d = byte_cnt_q + BCNT_W'(1);
        end
      end else if (byte_cnt_q != '0) begin
        // A byte in the expiry cycle takes the branch above, so it is never lost.
        if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          byte_cnt_d  = '0;
          tmo_d       = '0;
          frame_err_d = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      // Stream stopped: a word completing this cycle still counts, anything partial is dropped.
      if (drop_i) begin
        byte_cnt_d = '0;
        tmo_d      = '0;
        if ((byte_cnt_q != '0) && !complete_c) begin
          frame_err_d = 1'b1;
        end
      end
    end
  end

  // Assembler state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg_q     <= '0;
      byte_cnt_q  <= '0;
      tmo_q       <= '0;
      frame_err_q <= 1'b0;
    end else begin
      shreg_q     <= shreg_d;
      byte_cnt_q  <= byte_cnt_d;
      tmo_q       <= tmo_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign frame_err_o = frame_err_q;

endmodule

// File: rtl/demod_seq.sv
// Demod pipeline sequencer: sample strobes, packet flush and output-valid marking.
module demod_seq
  import fm_demod_pkg::*;
#(
  parameter int unsigned PKT_SAMPLES = 1024,
  parameter int unsigned PIPE_DELAY  = 7,
  parameter int unsigned TIMEOUT     = 1024,
  parameter int unsigned FLUSH_GAP   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                byte_valid_i,
  input  logic [BYTE_W-1:0]   byte_i,
  output logic [SAMPLE_W-1:0] sample_o,
  output logic                sample_valid_o,
  output logic                out_valid_o,
  output logic                done_o,
  output logic                frame_err_o,
  output logic                overrun_o,
  output logic                busy_o
);

  localparam int unsigned CNT_W = $clog2(PKT_SAMPLES + PIPE_DELAY + 1);
  localparam int unsigned GAP_W = cnt_width(FLUSH_GAP);
  localparam int unsigned FL_W  = cnt_width(PIPE_DELAY + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] samp_cnt_q, samp_cnt_d;
  logic [CNT_W-1:0] strobe_cnt_q, strobe_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [FL_W-1:0]  flush_cnt_q, flush_cnt_d;
  iq_sample_t       sample_q, sample_d;
  logic             sample_valid_q, sample_valid_d;
  logic             ov_pend_q, ov_pend_d;
  logic             out_valid_q, out_valid_d;
  logic             done_q, done_d;
  logic             overrun_q, overrun_d;
  logic             busy_q, busy_d;

  logic                en_c;
  logic                drop_c;
  logic [SAMPLE_W-1:0] word_c;
  logic                complete_c;

  assign en_c   = (state_q == COLLECT);
  assign drop_c = en_c && !start_i;

  iq_assembler #(
    .TIMEOUT (TIMEOUT)
  ) u_asm (
    .clk          (clk),
    .rst          (rst),
    .en_i         (en_c),
    .drop_i       (drop_c),
    .byte_valid_i (byte_valid_i),
    .byte_i       (byte_i),
    .word_c       (word_c),
    .complete_c   (complete_c),
    .frame_err_o  (frame_err_o)
  );

  // Next state, counters and strobe generation.
  always_comb begin
    state_d        = state_q;
    samp_cnt_d     = samp_cnt_q;
    strobe_cnt_d   = strobe_cnt_q;
    gap_cnt_d      = gap_cnt_q;
    flush_cnt_d    = flush_cnt_q;
    sample_d       = sample_q;
    sample_valid_d = 1'b0;
    done_d         = 1'b0;
    overrun_d      = overrun_q;
    out_valid_d    = ov_pend_q;

    case (state_q)
      IDLE: begin
        samp_cnt_d   = '0;
        strobe_cnt_d = '0;
        gap_cnt_d    = '0;
        flush_cnt_d  = '0;
        if (start_i) begin
          state_d   = COLLECT;
          overrun_d = 1'b0;
        end
      end

      COLLECT: begin
        if (complete_c) begin
          sample_d       = word_c;
          sample_valid_d = 1'b1;
          samp_cnt_d     = samp_cnt_q + CNT_W'(1);
          strobe_cnt_d   = strobe_cnt_q + CNT_W'(1);
        end
        // Full packet and stream stop may coincide; either way one entry into FLUSH.
        if ((complete_c && (samp_cnt_q == CNT_W'(PKT_SAMPLES - 1))) || !start_i) begin
          state_d     = FLUSH;
          gap_cnt_d   = '0;
          flush_cnt_d = '0;
        end
      end

      FLUSH: begin
        if (byte_valid_i) begin
          overrun_d = 1'b1;
        end
        if (gap_cnt_q == GAP_W'(FLUSH_GAP - 1)) begin
          gap_cnt_d      = '0;
          sample_d       = '0;
          sample_valid_d = 1'b1;
          strobe_cnt_d   = strobe_cnt_q + CNT_W'(1);
          flush_cnt_d    = flush_cnt_q + FL_W'(1);
          if (flush_cnt_q == FL_W'(PIPE_DELAY - 1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Strobe k drives a real pipeline output once the first PIPE_DELAY strobes have filled it.
    ov_pend_d = sample_valid_d && (strobe_cnt_q >= CNT_W'(PIPE_DELAY));
    busy_d    = (state_d != IDLE);
  end

  // Sequencer registers; reset aborts any packet in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      samp_cnt_q     <= '0;
      strobe_cnt_q   <= '0;
      gap_cnt_q      <= '0;
      flush_cnt_q    <= '0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      ov_pend_q      <= 1'b0;
      out_valid_q    <= 1'b0;
      done_q         <= 1'b0;
      overrun_q      <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      samp_cnt_q     <= samp_cnt_d;
      strobe_cnt_q   <= strobe_cnt_d;
      gap_cnt_q      <= gap_cnt_d;
      flush_cnt_q    <= flush_cnt_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
      ov_pend_q      <= ov_pend_d;
      out_valid_q    <= out_valid_d;
      done_q         <= done_d;
      overrun_q      <= overrun_d;
      busy_q         <= busy_d;
    end
  end

  assign sample_o       = sample_q;
  assign sample_valid_o = sample_valid_q;
  assign out_valid_o    = out_valid_q;
  assign done_o         = done_q;
  assign overrun_o      = overrun_q;
  assign busy_o         = busy_q;

endmodule

// File: tb/tb_demod_seq.sv
// Bench for demod_seq: event-trace scoreboard built from the packet rules.
module tb_demod_seq;

  localparam int PIPE_DELAY = 7;
  localparam int TIMEOUT    = 1024;
  localparam int FLUSH_GAP  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        byte_valid_i;
  logic [7:0]  byte_i;
  logic [31:0] sample_o;
  logic        sample_valid_o, out_valid_o, done_o, frame_err_o, overrun_o, busy_o;

  demod_seq dut (
    .clk            (clk),
    .rst            (rst),
    .start_i        (start_i),
    .byte_valid_i   (byte_valid_i),
    .byte_i         (byte_i),
    .sample_o       (sample_o),
    .sample_valid_o (sample_valid_o),
    .out_valid_o    (out_valid_o),
    .done_o         (done_o),
    .frame_err_o    (frame_err_o),
    .overrun_o      (overrun_o),
    .busy_o         (busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed events, stamped with the cycle in which they are visible.
  int          obs_sv_t[$];
  logic [31:0] obs_sv_d[$];
  int          obs_ov[$];
  int          obs_done[$];
  int          obs_ferr[$];

  always @(negedge clk) begin
    if (rst) begin
      if (sample_valid_o) begin
        obs_sv_t.push_back(cyc);
        obs_sv_d.push_back(sample_o);
      end
      if (out_valid_o) obs_ov.push_back(cyc);
      if (done_o)      obs_done.push_back(cyc);
      if (frame_err_o) obs_ferr.push_back(cyc);
    end
  end

  // Expected events and reference-model state.
  int          exp_sv_t[$];
  logic [31:0] exp_sv_d[$];
  int          exp_ov[$];
  int          exp_done[$];
  int          exp_ferr[$];
  logic [7:0]  part[$];
  int          lastc = 0;
  int          sv_rd = 0, ov_rd = 0, done_rd = 0, ferr_rd = 0;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Flush strobes and output-valid marks for the packet whose FLUSH is entered after cycle d.
  task automatic build_flush(input int d);
    for (int j = 1; j <= PIPE_DELAY; j++) begin
      exp_sv_t.push_back(d + 1 + FLUSH_GAP * j);
      exp_sv_d.push_back(32'h0);
    end
    exp_done.push_back(d + 1 + FLUSH_GAP * PIPE_DELAY);
    for (int k = PIPE_DELAY; k < exp_sv_t.size(); k++) exp_ov.push_back(exp_sv_t[k] + 1);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit end_pkt);
    int acc;
    byte_valid_i = 1'b1;
    byte_i       = b;
    if (end_pkt) start_i = 1'b0;
    acc = cyc;
    if ((part.size() > 0) && ((acc - lastc - 1) >= TIMEOUT)) begin
      exp_ferr.push_back(lastc + TIMEOUT + 1);
      part.delete();
    end
    part.push_back(b);
    lastc = acc;
    if (part.size() == 4) begin
      exp_sv_t.push_back(acc + 1);
      exp_sv_d.push_back({part[0], part[1], part[2], part[3]});
      part.delete();
    end
    if (end_pkt) begin
      if (part.size() > 0) begin
        exp_ferr.push_back(acc + 1);
        part.delete();
      end
      build_flush(acc);
    end
    @(posedge clk);
    #1;
    byte_valid_i = 1'b0;
  endtask

  task automatic drop_start();
    start_i = 1'b0;
    if (part.size() > 0) begin
      exp_ferr.push_back(cyc + 1);
      part.delete();
    end
    build_flush(cyc);
  endtask

  task automatic inject_byte();
    byte_valid_i = 1'b1;
    byte_i       = 8'($urandom);
    @(posedge clk);
    #1;
    byte_valid_i = 1'b0;
  endtask

  task automatic begin_pkt();
    start_i = 1'b1;
    @(posedge clk);
    #1;
    chk("busy_at_start", 32'(busy_o), 32'h1);
  endtask

  task automatic compare_all();
    chk("sv_count", obs_sv_t.size() - sv_rd, exp_sv_t.size());
    for (int i = 0; (i < exp_sv_t.size()) && (sv_rd + i < obs_sv_t.size()); i++) begin
      chk("sv_cycle", obs_sv_t[sv_rd + i], exp_sv_t[i]);
      chk("sv_data", obs_sv_d[sv_rd + i], exp_sv_d[i]);
    end
    chk("ov_count", obs_ov.size() - ov_rd, exp_ov.size());
    for (int i = 0; (i < exp_ov.size()) && (ov_rd + i < obs_ov.size()); i++)
      chk("ov_cycle", obs_ov[ov_rd + i], exp_ov[i]);
    chk("done_count", obs_done.size() - done_rd, exp_done.size());
    for (int i = 0; (i < exp_done.size()) && (done_rd + i < obs_done.size()); i++)
      chk("done_cycle", obs_done[done_rd + i], exp_done[i]);
    chk("ferr_count", obs_ferr.size() - ferr_rd, exp_ferr.size());
    for (int i = 0; (i < exp_ferr.size()) && (ferr_rd + i < obs_ferr.size()); i++)
      chk("ferr_cycle", obs_ferr[ferr_rd + i], exp_ferr[i]);
    sv_rd   = obs_sv_t.size();
    ov_rd   = obs_ov.size();
    done_rd = obs_done.size();
    ferr_rd = obs_ferr.size();
    exp_sv_t.delete();
    exp_sv_d.delete();
    exp_ov.delete();
    exp_done.delete();
    exp_ferr.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_sample"},   sample_o, 32'h0);
    chk({tag, "_sv"},       32'(sample_valid_o), 32'h0);
    chk({tag, "_ov"},       32'(out_valid_o), 32'h0);
    chk({tag, "_done"},     32'(done_o), 32'h0);
    chk({tag, "_ferr"},     32'(frame_err_o), 32'h0);
    chk({tag, "_overrun"},  32'(overrun_o), 32'h0);
    chk({tag, "_busy"},     32'(busy_o), 32'h0);
  endtask

  initial begin
    logic [7:0] pat [4];
    pat = '{8'h12, 8'h34, 8'h56, 8'h78};
    rst          = 1'b0;
    start_i      = 1'b0;
    byte_valid_i = 1'b0;
    byte_i       = 8'h00;

    // Reset state.
    idle(2);
    chk_all_zero("reset");
    rst = 1'b1;
    idle(1);

    // Full packet, back-to-back bytes; stream stops together with the last byte.
    begin_pkt();
    for (int i = 0; i < 1024; i++)
      for (int b = 0; b < 4; b++) send_byte(pat[b], (i == 1023) && (b == 3));
    idle(40);
    compare_all();
    chk("full_busy_after", 32'(busy_o), 32'h0);
    chk("full_overrun_after", 32'(overrun_o), 32'h0);

    // Timeout discard, byte exactly at expiry, random samples, then abort with one byte pending.
    begin_pkt();
    send_byte(8'($urandom), 1'b0);
    send_byte(8'($urandom), 1'b0);
    idle(TIMEOUT);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b0);
    send_byte(8'hDD, 1'b0);
    send_byte(8'($urandom), 1'b0);
    idle(TIMEOUT - 1);
    for (int b = 0; b < 3; b++) send_byte(8'($urandom), 1'b0);
    for (int i = 0; i < 10; i++)
      for (int b = 0; b < 4; b++) begin
        idle(int'($urandom_range(0, 3)));
        send_byte(8'($urandom), 1'b0);
      end
    idle(int'($urandom_range(0, 2)));
    send_byte(8'($urandom), 1'b0);
    idle(2);
    drop_start();
    idle(40);
    compare_all();

    // Short packet with bytes arriving during FLUSH.
    begin_pkt();
    for (int i = 0; i < 3; i++)
      for (int b = 0; b < 4; b++) begin
        idle(int'($urandom_range(0, 2)));
        send_byte(8'($urandom), 1'b0);
      end
    idle(1);
    drop_start();
    idle(3);
    chk("overrun_before", 32'(overrun_o), 32'h0);
    inject_byte();
    chk("overrun_set", 32'(overrun_o), 32'h1);
    idle(5);
    inject_byte();
    idle(40);
    compare_all();
    chk("overrun_sticky", 32'(overrun_o), 32'h1);
    begin_pkt();
    chk("overrun_cleared", 32'(overrun_o), 32'h0);

    // Reset asserted mid-FLUSH: immediate zero outputs and no done afterwards.
    for (int i = 0; i < 2; i++)
      for (int b = 0; b < 4; b++) send_byte(8'($urandom_range(1, 255)), 1'b0);
    drop_start();
    idle(3);
    #2;
    rst = 1'b0;
    #1;
    chk_all_zero("async_rst");
    exp_sv_t.delete();
    exp_sv_d.delete();
    exp_ov.delete();
    exp_done.delete();
    exp_ferr.delete();
    part.delete();
    sv_rd   = obs_sv_t.size();
    ov_rd   = obs_ov.size();
    done_rd = obs_done.size();
    ferr_rd = obs_ferr.size();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(40);
    chk("no_done_after_rst", obs_done.size() - done_rd, 0);
    chk("no_strobe_after_rst", obs_sv_t.size() - sv_rd, 0);
    chk("idle_after_rst", 32'(busy_o), 32'h0);

    // Next packet after reset starts again at strobe index 0.
    begin_pkt();
    for (int i = 0; i < 8; i++)
      for (int b = 0; b < 4; b++) begin
        if (!((i == 7) && (b == 3))) idle(int'($urandom_range(0, 1)));
        send_byte(8'($urandom), (i == 7) && (b == 3));
      end
    idle(40);
    compare_all();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
